menc_elec_sincos: RTL and testbench

- Multi-channel successor to the single-encoder sin/cos lookup.
- For each of N_CH motor encoders, computes the electrical angle as ((menc * poles) mod 2^MENC_W) + per-channel offset.
- Looks up float32 sine and cosine from one shared time-multiplexed table.
- Emits one {channel, sin, cos} result per channel over a valid/ready stream.
- Sits between the encoder capture logic and the FOC current-loop transforms.

---
 rtl/menc_sincos_pkg.sv | 15 +
 rtl/menc_elec_sincos_if.sv | 13 +
 rtl/menc_sincos_lut.sv | 74 +++++++
 rtl/menc_elec_sincos.sv | 130 +++++++++++++
 tb/tb_menc_elec_sincos.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/menc_sincos_pkg.sv
// Shared types and constants for the multi-channel electrical-angle sin/cos block.
package menc_sincos_pkg;

    typedef enum logic [2:0] {IDLE, ANGLE, SIN, COS, WAIT, OUT} state_t;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;

    // Table entries per quarter electrical turn.
    function automatic int quarter_turn(input int angle_w);
        return 1 << (angle_w - 2);
    endfunction

endpackage

// File: rtl/menc_elec_sincos_if.sv
// Result stream of menc_elec_sincos: one {channel, sin, cos} beat per channel.
interface menc_elec_sincos_if #(
    parameter int CH_W = 1
);
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [31:0]     out_sin;
    logic [31:0]     out_cos;

    modport master (output out_valid, out_ch, out_sin, out_cos, input out_ready);
    modport slave  (input out_valid, out_ch, out_sin, out_cos, output out_ready);
endinterface

// File: rtl/menc_sincos_lut.sv
// Float32 sine ROM over one electrical turn (2^ANGLE_W entries) with a TABLE_LAT-deep
// registered output. Quadrant points are exact so sin/cos hit 0 and +-1 cleanly.
module menc_sincos_lut
    import menc_sincos_pkg::*;
#(
    parameter int ANGLE_W   = 11,
    parameter int TABLE_LAT = 1
) (
    input  logic               c,
    input  logic               rst_n,
    input  logic [ANGLE_W-1:0] addr,
    output logic [31:0]        dout
);
    localparam int  DEPTH = 1 << ANGLE_W;
    localparam int  QTR   = quarter_turn(ANGLE_W);
    localparam real PI_2  = 1.5707963267948966;

    // Exponent/mantissa of a float32 for 0 < v < 1 (sign handled by caller).
    function automatic logic [30:0] f32_mag(input real v);
        real         x;
        int          e;
        logic [23:0] m;
        x = v;
        e = 0;
        for (int k = 0; k < 32; k++) begin
            if (x < 1.0) begin
                x = x * 2.0;
                e = e - 1;
            end
        end
        m = 24'($rtoi((x - 1.0) * 8388608.0 + 0.5));
        if (m == 24'h80_0000) begin
            m = '0;
            e = e + 1;
        end
        return {8'(e + 127), m[22:0]};
    endfunction

    function automatic logic [31:0] sin_word(input int i);
        int quad;
        int j;
        quad = i / QTR;
        j    = i % QTR;
        if (j == 0) begin
            case (quad)
                1:       return FP_ONE;
                3:       return FP_NEG_ONE;
                default: return FP_ZERO;
            endcase
        end
        if (quad % 2 == 1) j = QTR - j;
        return {(quad >= 2), f32_mag($sin(PI_2 * real'(j) / real'(QTR)))};
    endfunction

    logic [31:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = sin_word(i);
    end

    logic [TABLE_LAT-1:0][31:0] pipe;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= rom[addr];
            for (int i = 1; i < TABLE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[TABLE_LAT-1];

endmodule

// File: rtl/menc_elec_sincos.sv
// Per-channel electrical angle -> float32 sin/cos via one shared ROM, streamed out.
// MENC_ELEC_SINCOS_DROPCNT_EN builds the saturating dropped-start counter.
module menc_elec_sincos
    import menc_sincos_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int MENC_W    = 14,
    parameter int ANGLE_W   = 11,
    parameter int POLE_W    = 8,
    parameter int TABLE_LAT = 1
) (
    input  logic                    c,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_CH*MENC_W-1:0]  menc,
    input  logic [N_CH*ANGLE_W-1:0] offset,
    input  logic [POLE_W-1:0]       poles,
    output logic                    busy,
    output logic [15:0]             drop_cnt,
    menc_elec_sincos_if.master      out_if
);
    localparam int                 CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int                 STAGES  = TABLE_LAT;
    localparam logic [ANGLE_W-1:0] QTR     = ANGLE_W'(quarter_turn(ANGLE_W));
    localparam logic [CH_W-1:0]    LAST_CH = CH_W'(N_CH - 1);

    state_t state, state_nxt;

    logic [N_CH-1:0][MENC_W-1:0]  sh_menc;
    logic [N_CH-1:0][ANGLE_W-1:0] sh_off;
    logic [POLE_W-1:0]            sh_poles;
    logic [CH_W-1:0]              ch;
    logic [MENC_W-1:0]            prod;
    logic [ANGLE_W-1:0]           ang, addr_s, lut_addr;
    logic [31:0]                  lut_dout, sin_q, cos_q;
    logic [STAGES:0][1:0]         vld_pipe;   // bit0 = sine word in flight, bit1 = cosine
    logic                         accept, last;

    assign prod   = sh_menc[ch] * MENC_W'(sh_poles);
    assign addr_s = ang + sh_off[ch];
    assign accept = (state == OUT) && out_if.out_ready;
    assign last   = (ch == LAST_CH);
    assign busy   = (state != IDLE);

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ANGLE;
            ANGLE:   state_nxt = SIN;
            SIN:     state_nxt = COS;
            COS:     state_nxt = WAIT;
            WAIT:    if (vld_pipe[STAGES][1]) state_nxt = OUT;
            OUT:     if (out_if.out_ready) state_nxt = last ? IDLE : ANGLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sh_menc  <= '0;
            sh_off   <= '0;
            sh_poles <= '0;
            ch       <= '0;
            ang      <= '0;
            lut_addr <= '0;
        end else begin
            if (state == IDLE && start) begin
                sh_menc  <= menc;
                sh_off   <= offset;
                sh_poles <= poles;
                ch       <= '0;
            end
            if (accept && !last)  ch <= ch + CH_W'(1);
            // Top ANGLE_W bits of the mod-2^MENC_W product are the table index.
            if (state == ANGLE)   ang <= ANGLE_W'(prod >> (MENC_W - ANGLE_W));
            if (state == SIN)     lut_addr <= addr_s;
            if (state == COS)     lut_addr <= addr_s + QTR;
        end
    end

    // Tags ride alongside the address so each ROM word is captured into the right register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= {state == COS, state == SIN};
            for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            if (vld_pipe[STAGES][0]) sin_q <= lut_dout;
            if (vld_pipe[STAGES][1]) cos_q <= lut_dout;
        end
    end

    menc_sincos_lut #(
        .ANGLE_W   (ANGLE_W),
        .TABLE_LAT (TABLE_LAT)
    ) u_lut (
        .c     (c),
        .rst_n (rst_n),
        .addr  (lut_addr),
        .dout  (lut_dout)
    );

    assign out_if.out_valid = (state == OUT);
    assign out_if.out_ch    = ch;
    assign out_if.out_sin   = sin_q;
    assign out_if.out_cos   = cos_q;

`ifdef MENC_ELEC_SINCOS_DROPCNT_EN
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n)                                       drop_cnt <= '0;
        else if (start && busy && drop_cnt != 16'hFFFF)   drop_cnt <= drop_cnt + 16'd1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_menc_elec_sincos.sv
// Scoreboard bench for menc_elec_sincos: a real-math model predicts every result beat.
module tb_menc_elec_sincos;
    localparam int  N_CH      = 2;
    localparam int  MENC_W    = 14;
    localparam int  ANGLE_W   = 11;
    localparam int  POLE_W    = 8;
    localparam int  TABLE_LAT = 1;
    localparam real PI        = 3.14159265358979323846;
`ifdef MENC_ELEC_SINCOS_DROPCNT_EN
    localparam int  DROP_EXP  = 3;
`else
    localparam int  DROP_EXP  = 0;
`endif

    typedef struct packed {
        logic        ch;
        logic [31:0] sw;
        logic [31:0] cw;
    } exp_t;

    logic                    c = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [N_CH*MENC_W-1:0]  menc = '0;
    logic [N_CH*ANGLE_W-1:0] offset = '0;
    logic [POLE_W-1:0]       poles = '0;
    logic                    busy;
    logic [15:0]             drop_cnt;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    menc_elec_sincos_if #(.CH_W(1)) oif ();

    menc_elec_sincos #(
        .N_CH(N_CH), .MENC_W(MENC_W), .ANGLE_W(ANGLE_W), .POLE_W(POLE_W), .TABLE_LAT(TABLE_LAT)
    ) dut (
        .c(c), .rst_n(rst_n), .start(start), .menc(menc), .offset(offset), .poles(poles),
        .busy(busy), .drop_cnt(drop_cnt), .out_if(oif)
    );

    always #5 c = ~c;

    function automatic logic [31:0] f32(input real v);
        real         x;
        int          e;
        logic [23:0] m;
        logic        sg;
        if (v > -1.0e-9 && v < 1.0e-9) return 32'h0;
        sg = (v < 0.0);
        x  = sg ? -v : v;
        e  = 0;
        for (int k = 0; k < 64; k++) begin
            if (x >= 2.0) begin x = x / 2.0; e++; end
            else if (x < 1.0) begin x = x * 2.0; e--; end
        end
        m = 24'($rtoi((x - 1.0) * 8388608.0 + 0.5));
        if (m[23]) begin m = '0; e++; end
        return {sg, 8'(e + 127), m[22:0]};
    endfunction

    function automatic bit near(input logic [31:0] a, input logic [31:0] b);
        int d;
        if (a === b) return 1'b1;
        if (a[31] !== b[31]) return 1'b0;
        d = int'(a[30:0]) - int'(b[30:0]);
        return (d >= -1) && (d <= 1);
    endfunction

    task automatic push_exp(input int k, input logic [13:0] m, input logic [10:0] o, input logic [7:0] p);
        exp_t e;
        int   pr, a;
        real  th;
        pr   = (int'(m) * int'(p)) & 'h3FFF;
        a    = ((pr >> 3) + int'(o)) & 'h7FF;
        th   = 2.0 * PI * real'(a) / 2048.0;
        e.ch = 1'(k);
        e.sw = f32($sin(th));
        e.cw = f32($cos(th));
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [13:0] m0, input logic [13:0] m1,
                            input logic [10:0] o0, input logic [10:0] o1, input logic [7:0] p);
        push_exp(0, m0, o0, p);
        push_exp(1, m1, o1, p);
        @(posedge c); #1;
        menc = {m1, m0}; offset = {o1, o0}; poles = p; start = 1'b1;
        @(posedge c); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge c); n++; end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle busy=%b required=0", tag, busy); end
    endtask

    // Result monitor: every accepted beat is popped from the scoreboard and compared.
    always @(negedge c) begin
        if (rst_n && oif.out_valid === 1'b1 && oif.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_beat ch=%0d required=none", oif.out_ch);
            end else begin
                mon_e = sb.pop_front();
                n_cmp += 3;
                if (oif.out_ch !== mon_e.ch) begin
                    n_bad++; $display("FAIL beat_ch got=%0d required=%0d", oif.out_ch, mon_e.ch);
                end
                if (!near(oif.out_sin, mon_e.sw)) begin
                    n_bad++; $display("FAIL beat_sin ch=%0d got=%h required=%h", mon_e.ch, oif.out_sin, mon_e.sw);
                end
                if (!near(oif.out_cos, mon_e.cw)) begin
                    n_bad++; $display("FAIL beat_cos ch=%0d got=%h required=%h", mon_e.ch, oif.out_cos, mon_e.cw);
                end
            end
        end
    end

    task automatic test_reset();
        oif.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge c);
        #1 rst_n = 1'b1;
        @(negedge c);
        n_cmp += 6;
        if (busy !== 1'b0)          begin n_bad++; $display("FAIL rst_busy got=%b required=0", busy); end
        if (oif.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b required=0", oif.out_valid); end
        if (oif.out_ch !== 1'b0)    begin n_bad++; $display("FAIL rst_ch got=%0d required=0", oif.out_ch); end
        if (oif.out_sin !== 32'h0)  begin n_bad++; $display("FAIL rst_sin got=%h required=0", oif.out_sin); end
        if (oif.out_cos !== 32'h0)  begin n_bad++; $display("FAIL rst_cos got=%h required=0", oif.out_cos); end
        if (drop_cnt !== 16'h0)     begin n_bad++; $display("FAIL rst_drop got=%0d required=0", drop_cnt); end
    endtask

    task automatic test_basic();
        int lat, gap;
        oif.out_ready = 1'b1;
        do_start(14'h0000, 14'h1000, 11'h000, 11'h000, 8'd1);
        lat = 0;
        do begin @(posedge c); @(negedge c); lat++; end
        while (oif.out_valid !== 1'b1 && lat < 40);
        n_cmp++;
        if (lat != 4 + TABLE_LAT) begin n_bad++; $display("FAIL first_latency got=%0d required=%0d", lat, 4 + TABLE_LAT); end
        gap = 0;
        do begin @(posedge c); @(negedge c); gap++; end
        while (!(oif.out_valid === 1'b1 && oif.out_ch === 1'b1) && gap < 40);
        n_cmp++;
        if (gap != 5 + TABLE_LAT) begin n_bad++; $display("FAIL ch1_spacing got=%0d required=%0d", gap, 5 + TABLE_LAT); end
        wait_idle("basic");
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL basic_pending got=%0d required=0", sb.size()); end
    endtask

    task automatic test_half_turn();
        do_start(14'h0800, 14'h1234, 11'h000, 11'h155, 8'd4);
        wait_idle("half");
        do_start(14'h2A5C, 14'h3F01, 11'h000, 11'h000, 8'd0);
        wait_idle("poles0");
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL half_pending got=%0d required=0", sb.size()); end
    endtask

    task automatic test_wrap();
        do_start(14'h3FFF, 14'h2000, 11'h7FF, 11'h400, 8'd1);
        wait_idle("wrap");
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL wrap_pending got=%0d required=0", sb.size()); end
    endtask

    task automatic test_stall();
        int n;
        oif.out_ready = 1'b0;
        do_start(14'h0155, 14'h2ABC, 11'h010, 11'h123, 8'd3);
        n = 0;
        while (oif.out_valid !== 1'b1 && n < 40) begin @(negedge c); n++; end
        menc = '1; offset = '1; poles = 8'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge c);
            n_cmp += 4;
            if (oif.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid cyc=%0d got=%b required=1", i, oif.out_valid); end
            if (oif.out_ch !== sb[0].ch) begin n_bad++; $display("FAIL stall_ch cyc=%0d got=%0d required=%0d", i, oif.out_ch, sb[0].ch); end
            if (!near(oif.out_sin, sb[0].sw)) begin n_bad++; $display("FAIL stall_sin cyc=%0d got=%h required=%h", i, oif.out_sin, sb[0].sw); end
            if (!near(oif.out_cos, sb[0].cw)) begin n_bad++; $display("FAIL stall_cos cyc=%0d got=%h required=%h", i, oif.out_cos, sb[0].cw); end
        end
        @(posedge c); #1 oif.out_ready = 1'b1;
        wait_idle("stall");
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL stall_pending got=%0d required=0", sb.size()); end
    endtask

    task automatic test_drop();
        oif.out_ready = 1'b1;
        do_start(14'h0321, 14'h1ABC, 11'h05A, 11'h6F0, 8'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge c); #1 start = 1'b1;
            @(posedge c); #1 start = 1'b0;
        end
        wait_idle("drop");
        @(negedge c);
        n_cmp += 2;
        if (drop_cnt !== 16'(DROP_EXP)) begin n_bad++; $display("FAIL drop_cnt got=%0d required=%0d", drop_cnt, DROP_EXP); end
        if (sb.size() != 0) begin n_bad++; $display("FAIL drop_pending got=%0d required=0", sb.size()); end
    endtask

    task automatic test_abort();
        int n;
        oif.out_ready = 1'b1;
        do_start(14'h0421, 14'h0777, 11'h033, 11'h044, 8'd2);
        n = 0;
        while (oif.out_ch !== 1'b1 && n < 40) begin @(negedge c); n++; end
        repeat (3) @(posedge c);
        #1 rst_n = 1'b0;
        #1;
        n_cmp += 7;
        if (busy !== 1'b0)          begin n_bad++; $display("FAIL abort_busy got=%b required=0", busy); end
        if (oif.out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got=%b required=0", oif.out_valid); end
        if (oif.out_ch !== 1'b0)    begin n_bad++; $display("FAIL abort_ch got=%0d required=0", oif.out_ch); end
        if (oif.out_sin !== 32'h0)  begin n_bad++; $display("FAIL abort_sin got=%h required=0", oif.out_sin); end
        if (oif.out_cos !== 32'h0)  begin n_bad++; $display("FAIL abort_cos got=%h required=0", oif.out_cos); end
        if (drop_cnt !== 16'h0)     begin n_bad++; $display("FAIL abort_drop got=%0d required=0", drop_cnt); end
        if (sb.size() != 1)         begin n_bad++; $display("FAIL abort_pending got=%0d required=1", sb.size()); end
        sb.delete();
        repeat (2) @(posedge c);
        #1 rst_n = 1'b1;
        do_start(14'h1111, 14'h0C00, 11'h100, 11'h000, 8'd3);
        wait_idle("after_abort");
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL after_abort_pending got=%0d required=0", sb.size()); end
    endtask

    initial begin
        oif.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_half_turn();
        test_wrap();
        test_stall();
        test_drop();
        test_abort();
        repeat (2) @(posedge c);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
